// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// if_fetch_queue : credit-limited instruction fetch with in-order tag queue,
//                  response FIFO and ID output register.        Rev 1.0
// ============================================================================
module if_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_in,
  input  logic              flush_in,
  input  logic              branch_taken_in,
  input  logic [ADDR_W-1:0] branch_addr_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instruction_out,
  output logic              valid_out
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_STEP  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_req_en;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_discard;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_fifo_wr;
  logic [c_PTR_W-1:0] r_fifo_rd;
  logic [c_PTR_W-1:0] r_tag_wr;
  logic [c_PTR_W-1:0] r_tag_rd;
  logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];
  logic [DATA_W-1:0]  r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  r_tag_mem    [DEPTH];
  logic [ADDR_W-1:0]  r_pc_out;
  logic [DATA_W-1:0]  r_instr_out;
  logic               r_valid_out;

  logic               w_credit;
  logic               w_grant;
  logic               w_live_rsp;
  logic               w_discard_rsp;
  logic               w_fifo_empty;
  logic               w_advance;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic [ADDR_W-1:0]  w_rsp_pc;

  // Stale in-flight requests and buffered words both consume credit.
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, r_count}) < {1'b0, c_DEPTH};
  assign imem_req      = r_req_en && w_credit && !branch_taken_in;
  assign imem_addr     = r_fetch_pc;
  assign w_grant       = imem_req && imem_gnt;

  assign w_discard_rsp = imem_rvalid && (r_discard != '0);
  assign w_live_rsp    = imem_rvalid && (r_discard == '0);
  assign w_rsp_pc      = r_tag_mem[r_tag_rd];

  assign w_fifo_empty  = (r_count == '0);
  assign w_advance     = !freeze_in && !flush_in;
  assign w_pop         = w_advance && !w_fifo_empty;
  assign w_bypass      = w_advance && w_fifo_empty && w_live_rsp;
  assign w_push        = w_live_rsp && !w_bypass;

  assign pc_out          = r_pc_out;
  assign instruction_out = r_instr_out;
  assign valid_out       = r_valid_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_en      <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_req_en      <= 1'b1;
      r_outstanding <= r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(imem_rvalid);
      if (branch_taken_in) begin
        // Every request still in flight after this edge belongs to the old path.
        r_fetch_pc <= branch_addr_in;
        r_discard  <= r_outstanding - c_CNT_W'(imem_rvalid);
        r_count    <= '0;
        r_fifo_wr  <= '0;
        r_fifo_rd  <= '0;
        r_tag_wr   <= '0;
        r_tag_rd   <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + c_STEP;
        end
        r_discard <= r_discard - c_CNT_W'(w_discard_rsp);
        r_count   <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        r_fifo_wr <= r_fifo_wr + c_PTR_W'(w_push);
        r_fifo_rd <= r_fifo_rd + c_PTR_W'(w_pop);
        r_tag_wr  <= r_tag_wr + c_PTR_W'(w_grant);
        r_tag_rd  <= r_tag_rd + c_PTR_W'(w_live_rsp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]    <= w_rsp_pc;
      r_fifo_instr[r_fifo_wr] <= imem_rdata;
    end
    if (w_grant) begin
      r_tag_mem[r_tag_wr] <= r_fetch_pc + c_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc_out    <= '0;
      r_instr_out <= '0;
      r_valid_out <= 1'b0;
    end else if (flush_in) begin
      r_pc_out    <= '0;
      r_instr_out <= '0;
      r_valid_out <= 1'b0;
    end else if (!freeze_in) begin
      if (w_pop) begin
        r_pc_out    <= r_fifo_pc[r_fifo_rd];
        r_instr_out <= r_fifo_instr[r_fifo_rd];
        r_valid_out <= 1'b1;
      end else if (w_bypass) begin
        r_pc_out    <= w_rsp_pc;
        r_instr_out <= imem_rdata;
        r_valid_out <= 1'b1;
      end else begin
        r_pc_out    <= '0;
        r_instr_out <= '0;
        r_valid_out <= 1'b0;
      end
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_live_rsp |-> (r_count != c_DEPTH));
  a_counters_bounded: assert property (@(posedge clk) disable iff (!rst)
    (r_outstanding <= c_DEPTH) && (r_count <= c_DEPTH) && (r_discard <= c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// Directed bench for if_fetch_queue: in-order memory model, queue-based
// reference of the ID stream and request credit, plus literal checkpoints.
module tb_if_fetch_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze_in, flush_in, branch_taken_in;
  logic [AW-1:0] branch_addr_in;
  logic          imem_req, imem_gnt, imem_rvalid;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] instruction_out;
  logic          valid_out;

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .freeze_in(freeze_in), .flush_in(flush_in),
    .branch_taken_in(branch_taken_in), .branch_addr_in(branch_addr_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out));

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
    int            epoch;
  } mreq_t;

  mreq_t         mq[$];      // memory: granted, not yet answered
  logic [AW-1:0] avail[$];   // answered on the live path, not yet handed to ID
  int            checks = 0, failures = 0, cyc = 0, lat = 1, epoch = 0;
  bit            running = 0;
  logic [AW-1:0] m_fetch = '0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic [DW-1:0] m_instr = '0;
  bit            fz = 0, fl = 0, br = 0, gnt = 1;
  logic [AW-1:0] baddr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check the request, model the edge, check outputs.
  task automatic step();
    bit    rv, stale, took, exp_req;
    int    inflight;
    mreq_t r;
    @(negedge clk);
    freeze_in = fz; flush_in = fl; branch_taken_in = br; branch_addr_in = baddr; imem_gnt = gnt;
    inflight = mq.size();
    rv = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1;
      r  = mq.pop_front();
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? r.addr : '0;
    #1;
    exp_req = running && !br && (inflight + avail.size() < DEPTH);
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(m_fetch));
    if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat, epoch});
    if (exp_req && gnt) m_fetch = m_fetch + 32'd4;
    @(posedge clk);
    cyc++;
    stale = rv && ((r.epoch != epoch) || br);
    took  = 0;
    if (fl) begin
      m_valid = 1'b0; m_pc = '0; m_instr = '0;
    end else if (!fz) begin
      if (avail.size() > 0) begin
        m_instr = avail.pop_front();
        m_pc    = m_instr + 32'd4;
        m_valid = 1'b1;
      end else if (rv && !stale) begin
        m_instr = r.addr;
        m_pc    = r.addr + 32'd4;
        m_valid = 1'b1;
        took    = 1;
      end else begin
        m_valid = 1'b0; m_pc = '0; m_instr = '0;
      end
    end
    if (rv && !stale && !took) avail.push_back(r.addr);
    if (br) begin
      avail.delete();
      epoch++;
      m_fetch = baddr;
    end
    running = 1;
    #1;
    chk("valid_out", 64'(valid_out), 64'(m_valid));
    chk("pc_out", 64'(pc_out), 64'(m_pc));
    chk("instruction_out", 64'(instruction_out), 64'(m_instr));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!valid_out && n < 20);
    if (!valid_out) begin
      checks++;
      failures++;
      $display("FAIL %s: valid_out not seen within 20 cycles", name);
    end
  endtask

  // Called just after a rising edge; reset lands between edges.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    freeze_in = 0; flush_in = 0; branch_taken_in = 0; imem_gnt = 0; imem_rvalid = 0;
    #1;
    chk("rst imem_req", 64'(imem_req), 64'd0);
    chk("rst imem_addr", 64'(imem_addr), 64'd0);
    chk("rst valid_out", 64'(valid_out), 64'd0);
    chk("rst pc_out", 64'(pc_out), 64'd0);
    chk("rst instruction_out", 64'(instruction_out), 64'd0);
    mq.delete(); avail.delete(); epoch++;
    running = 0; m_fetch = '0; m_valid = 1'b0; m_pc = '0; m_instr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; freeze_in = 0; flush_in = 0; branch_taken_in = 0; branch_addr_in = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init valid_out", 64'(valid_out), 64'd0);
    chk("init imem_req", 64'(imem_req), 64'd0);
    rst = 1'b1;

    // Zero-wait memory: release edge is cycle 0, first instruction at cycle 2.
    step(); step(); step();
    chk("first valid", 64'(valid_out), 64'd1);
    chk("first pc", 64'(pc_out), 64'd4);
    chk("first instr", 64'(instruction_out), 64'd0);
    step(); chk("second pc", 64'(pc_out), 64'd8);
    step(); chk("third pc", 64'(pc_out), 64'd12);
    step(); chk("fourth pc", 64'(pc_out), 64'd16);

    // ID stall for 6 cycles: output holds, credit runs out, nothing lost.
    fz = 1;
    repeat (6) step();
    chk("freeze hold pc", 64'(pc_out), 64'd16);
    chk("freeze req dropped", 64'(imem_req), 64'd0);
    fz = 0;
    step(); chk("after freeze pc", 64'(pc_out), 64'd20);
    repeat (6) step();

    // Branch with 3 slow requests in flight.
    gnt = 0;
    repeat (6) step();
    lat = 3; gnt = 1;
    repeat (3) step();
    br = 1; fl = 1; baddr = 32'h100;
    step();
    chk("branch bubble", 64'(valid_out), 64'd0);
    br = 0; fl = 0;
    wait_valid("branch target");
    chk("branch target pc", 64'(pc_out), 64'h104);
    chk("branch target instr", 64'(instruction_out), 64'h100);
    repeat (4) step();

    // Flush during freeze: bubble, then buffered words in order.
    fz = 1;
    repeat (3) step();
    fl = 1;
    step();
    chk("flush valid", 64'(valid_out), 64'd0);
    chk("flush pc", 64'(pc_out), 64'd0);
    fl = 0; fz = 0;
    step();
    chk("post flush valid", 64'(valid_out), 64'd1);
    repeat (6) step();

    // Address wrap at the top of the space.
    lat = 1;
    br = 1; fl = 1; baddr = 32'hFFFF_FFFC;
    step();
    br = 0; fl = 0;
    wait_valid("wrap target");
    chk("wrap pc0", 64'(pc_out), 64'd0);
    chk("wrap instr0", 64'(instruction_out), 64'hFFFF_FFFC);
    step();
    chk("wrap pc1", 64'(pc_out), 64'd4);
    chk("wrap instr1", 64'(instruction_out), 64'd0);
    repeat (3) step();

    // Reset with 2 requests outstanding.
    gnt = 0;
    repeat (6) step();
    lat = 3; gnt = 1;
    repeat (2) step();
    do_reset();
    lat = 1; gnt = 1;
    step(); step(); step();
    chk("restart valid", 64'(valid_out), 64'd1);
    chk("restart pc", 64'(pc_out), 64'd4);
    chk("restart instr", 64'(instruction_out), 64'd0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
